vga_frame_fetch: RTL and testbench

- Pixel-data stage that sits directly downstream of vga_sync_generator.
- Streams one frame of 24-bit RGB pixels from a word-addressed framebuffer, using an Avalon-MM style pipelined read master.
- Buffers the pixels in a small show-ahead FIFO and pops one pixel per visible cycle (blank_n_in high).
- Drives registered RGB/HS/VS/blank_n to the DAC with sync and data cycle-aligned.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_pixel_fifo.sv | 62 ++++++
 rtl/vga_frame_fetch.sv | 169 ++++++++++++++++
 tb/tb_vga_frame_fetch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the 800x480 VGA pixel path.
package vga_pkg;

  // One framebuffer word: 24-bit colour, red in the top byte.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // 800x480 timing, shared with vga_sync_generator.
  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 48;
  localparam int H_BACK    = 88;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 13;
  localparam int V_SYNC    = 3;
  localparam int V_BACK    = 32;
  localparam int PIXELS_PER_FRAME = H_VISIBLE * V_VISIBLE;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    FETCH   = 2'd1,
    DONE    = 2'd2,
    DRAIN   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Show-ahead pixel FIFO: dout is the head entry whenever empty is low.
// flush wins over push and pop issued in the same cycle.
module vga_pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  pixel_t        din,
  output pixel_t        dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; written only, no reset needed.
  always_ff @(posedge vga_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_frame_fetch.sv
// Streams one frame of pixels from a word-addressed framebuffer through a
// pipelined read master into a small FIFO, and pops one pixel per visible
// cycle into registered DAC outputs aligned with the delayed syncs.
//
// Read handshake: a request is accepted on a cycle where mem_read is high and
// mem_waitrequest is low; while stalled, mem_read and mem_address hold. Every
// accepted read returns exactly one mem_readdatavalid strobe, in order.
module vga_frame_fetch
  import vga_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FRAME_BASE   = 0,
  parameter int FRAME_PIXELS = 384000,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              blank_n_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [23:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              underflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [CW:0]       CREDITS    = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic              restart;
  logic              vs_d;
  logic              vs_rise;
  logic [ADDR_W-1:0] index;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW:0]       credit_sum;
  logic              accept;
  logic              push;
  logic              pop;
  pixel_t            fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  assign vs_rise = vs_in && !vs_d;
  assign accept  = mem_read && !mem_waitrequest;
  assign pop     = blank_n_in && !fifo_empty;
  assign outstanding_next = outstanding + CW'(accept) - CW'(mem_readdatavalid);

  // State register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) state <= WAIT_VS;
    else       state <= state_next;
  end

  // Next-state: a new frame either restarts at once or waits for in-flight
  // reads to drain so stale data never lands in the new frame.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    case (state)
      WAIT_VS: begin
        if (vs_rise) begin
          state_next = FETCH;
          restart    = 1'b1;
        end
      end
      FETCH, DONE: begin
        if (vs_rise) begin
          if (outstanding != '0 || outstanding_next != '0) begin
            state_next = DRAIN;
          end else begin
            state_next = FETCH;
            restart    = 1'b1;
          end
        end else if (state == FETCH && accept && index == LAST_INDEX) begin
          state_next = DONE;
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          state_next = FETCH;
          restart    = 1'b1;
        end
      end
      default: state_next = WAIT_VS;
    endcase
  end

  // Outputs of the fetch side: credit-limited requests and FIFO push.
  always_comb begin
    credit_sum  = {1'b0, fifo_count} + {1'b0, outstanding};
    mem_read    = (state == FETCH) && (credit_sum < CREDITS);
    mem_address = (state == FETCH) ? (BASE + index) : '0;
    push        = mem_readdatavalid && (state == FETCH || state == DONE) && !fifo_full;
  end

  // Request index, in-flight count and vsync edge detector.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      index       <= '0;
      outstanding <= '0;
      vs_d        <= 1'b0;
    end else begin
      vs_d        <= vs_in;
      outstanding <= outstanding_next;
      if (restart)     index <= '0;
      else if (accept) index <= index + 1'b1;
    end
  end

  vga_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .vga_clk (vga_clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (restart),
    .din     (pixel_t'(mem_readdata)),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Display registers: syncs and colour share the same one-cycle delay.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vga_hs      <= 1'b0;
      vga_vs      <= 1'b0;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      underflow   <= 1'b0;
    end else begin
      vga_hs      <= hs_in;
      vga_vs      <= vs_in;
      vga_blank_n <= blank_n_in;
      if (pop) begin
        vga_r <= fifo_dout.r;
        vga_g <= fifo_dout.g;
        vga_b <= fifo_dout.b;
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
      // Starvation before the first frame or across a restart is expected.
      if (blank_n_in && fifo_empty && state != WAIT_VS && state != DRAIN)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed bench for vga_frame_fetch with a small in-order memory slave model.
module tb_vga_frame_fetch;
  import vga_pkg::*;

  localparam int AW = 16;

  logic          vga_clk;
  logic          reset;
  logic          blank_n_in;
  logic          hs_in;
  logic          vs_in;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_waitrequest;
  logic [23:0]   mem_readdata;
  logic          mem_readdatavalid;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, vga_blank_n;
  logic          underflow;

  int vectors = 0;
  int miscompares = 0;

  vga_frame_fetch #(
    .ADDR_W       (AW),
    .FRAME_BASE   (256),
    .FRAME_PIXELS (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .vga_clk           (vga_clk),
    .reset             (reset),
    .blank_n_in        (blank_n_in),
    .hs_in             (hs_in),
    .vs_in             (vs_in),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .vga_r             (vga_r),
    .vga_g             (vga_g),
    .vga_b             (vga_b),
    .vga_hs            (vga_hs),
    .vga_vs            (vga_vs),
    .vga_blank_n       (vga_blank_n),
    .underflow         (underflow)
  );

  // Clock
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Memory slave model: in-order returns after 'lat' cycles, data = {tag, address}.
  typedef struct {
    logic [23:0] data;
    int          due;
  } req_t;

  req_t          pend_q[$];
  logic [AW-1:0] acc_log[$];
  logic [AW:0]   stall_log[$];
  int            cyc = 0;
  int            lat = 1;
  int            stall_len = 0;
  int            stall_left = 0;
  logic [AW-1:0] stall_addr = '0;
  logic [7:0]    tag = 8'h00;

  initial begin
    mem_waitrequest   = 1'b0;
    mem_readdata      = '0;
    mem_readdatavalid = 1'b0;
  end

  always @(negedge vga_clk) begin
    cyc++;
    if (reset) begin
      pend_q.delete();
      stall_left        = 0;
      mem_waitrequest   = 1'b0;
      mem_readdata      = '0;
      mem_readdatavalid = 1'b0;
    end else begin
      mem_readdatavalid = 1'b0;
      mem_readdata      = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      if (stall_left == 0 && stall_len > 0 && mem_read && mem_address == stall_addr) begin
        stall_left = stall_len;
        stall_len  = 0;
      end
      mem_waitrequest = (stall_left > 0);
      if (stall_left > 0) begin
        stall_log.push_back({mem_read, mem_address});
        stall_left--;
      end else if (mem_read) begin
        acc_log.push_back(mem_address);
        pend_q.push_back('{data: {tag, mem_address}, due: cyc + lat});
      end
    end
  end

  // Driver tasks
  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge vga_clk);
      #1;
    end
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1;
    step();
    vs_in = 1'b0;
  endtask

  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic wait_acc(int n, string name);
    int k = 0;
    while (acc_log.size() < n && k < 200) begin
      step();
      k++;
    end
    check(name, 32'(acc_log.size() >= n), 32'd1);
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, vga_r, vga_g, vga_b};
  endfunction

  function automatic logic [31:0] all_outs();
    return {8'h00, vga_r, vga_g, vga_b} | {24'h0, vga_hs, vga_vs, vga_blank_n,
            underflow, mem_read, 3'b000} | 32'(mem_address);
  endfunction

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    reset = 1'b1;
    blank_n_in = 1'b1;
    hs_in = 1'b1;
    vs_in = 1'b0;
    step(3);
    check("reset_outputs", all_outs(), 32'h0);
    check("reset_state", 32'(dut.state), 32'(WAIT_VS));
    reset = 1'b0;
    blank_n_in = 1'b0;
    hs_in = 1'b0;
    step(3);
    check("idle_no_read", 32'(acc_log.size()), 32'd0);

    // Zero-wait memory, full frame of 16 pixels
    lat = 1;
    vs_pulse();
    step(10);
    check("t1_prefill_credit", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 16; i++) begin
      blank_n_in = 1'b1;
      step();
      check($sformatf("t1_pixel%0d", i), rgb(), 32'h000100 + 32'(i));
    end
    check("t1_blank_n_delayed", 32'(vga_blank_n), 32'd1);
    blank_n_in = 1'b0;
    step();
    check("t1_blank_rgb_zero", rgb(), 32'h0);
    check("t1_no_underflow", 32'(underflow), 32'd0);
    check("t1_done_no_read", 32'(mem_read), 32'd0);
    check("t1_state_done", 32'(dut.state), 32'(DONE));
    check("t1_addr_count", 32'(acc_log.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("t1_addr%0d", i), 32'(acc_log[i]), 32'h100 + 32'(i));

    // Credit limit with slow memory and no pops
    lat = 5;
    acc_log.delete();
    vs_pulse();
    step(20);
    check("t2_credit_reads", 32'(acc_log.size()), 32'd4);
    check("t2_credit_stop", 32'(mem_read), 32'd0);
    check("t2_last_addr", 32'(acc_log[3]), 32'h103);
    blank_n_in = 1'b1;
    step();
    blank_n_in = 1'b0;
    check("t2_pop_pixel", rgb(), 32'h000100);
    step(3);
    check("t2_refill_read", 32'(acc_log.size()), 32'd5);
    check("t2_refill_addr", 32'(acc_log[4]), 32'h104);
    step(10);
    check("t2_credit_hold", 32'(acc_log.size()), 32'd5);
    check("t2_credit_hold_rd", 32'(mem_read), 32'd0);

    // waitrequest stall on 0x102
    lat = 1;
    acc_log.delete();
    stall_log.delete();
    stall_addr = 16'h0102;
    stall_len = 3;
    vs_pulse();
    step(15);
    check("t3_stall_cycles", 32'(stall_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t3_stall%0d", i), 32'(stall_log[i]), 32'h10102);
    check("t3_accepts", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_addr%0d", i), 32'(acc_log[i]), 32'h100 + 32'(i));

    // vs_rise with 3 reads outstanding
    lat = 5;
    tag = 8'hAA;
    stall_addr = 16'h0103;
    stall_len = 2;
    acc_log.delete();
    vs_pulse();
    wait_acc(3, "t5_three_issued");
    step();
    vs_in = 1'b1;
    tag = 8'h00;
    step();
    vs_in = 1'b0;
    check("t5_state_drain", 32'(dut.state), 32'(DRAIN));
    check("t5_drain_no_read", 32'(mem_read), 32'd0);
    acc_log.delete();
    step(20);
    check("t5_restart_count", 32'(acc_log.size()), 32'd4);
    check("t5_restart_addr", 32'(acc_log[0]), 32'h100);
    blank_n_in = 1'b1;
    step();
    check("t5_first_pixel", rgb(), 32'h000100);
    step();
    check("t5_second_pixel", rgb(), 32'h000101);
    blank_n_in = 1'b0;
    check("t5_no_underflow", 32'(underflow), 32'd0);

    // Starvation: silent before first frame, sticky after
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    lat = 40;
    acc_log.delete();
    blank_n_in = 1'b1;
    step(10);
    check("t4_pre_vs_underflow", 32'(underflow), 32'd0);
    check("t4_pre_vs_rgb", rgb(), 32'h0);
    check("t4_pre_vs_reads", 32'(acc_log.size()), 32'd0);
    vs_pulse();
    step(3);
    check("t4_starve_rgb", rgb(), 32'h0);
    check("t4_underflow_set", 32'(underflow), 32'd1);
    step(60);
    check("t4_underflow_sticky", 32'(underflow), 32'd1);

    // Reset mid-FETCH
    hs_in = 1'b1;
    step();
    check("t6_pre_state", 32'(dut.state), 32'(FETCH));
    check("t6_pre_hs", 32'(vga_hs), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_reset_outputs", all_outs(), 32'h0);
    step(2);
    reset = 1'b0;
    hs_in = 1'b0;
    blank_n_in = 1'b0;
    lat = 1;
    acc_log.delete();
    step(10);
    check("t6_no_reads", 32'(acc_log.size()), 32'd0);
    check("t6_state_wait", 32'(dut.state), 32'(WAIT_VS));
    vs_pulse();
    step(5);
    check("t6_resume_addr", 32'(acc_log[0]), 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
